// File: rtl/store_rmw_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_rmw_unit_pkg
// Shared definitions for the MEM-stage store path:
//   - mem_size_e : store/load size encodings, shared with the load-side
//                  masking unit (00 none, 01 byte, 10 halfword, 11 word)
//   - state_e    : read-modify-write sequencer states
//   - is_misaligned() : alignment check for a size / byte-offset pair
// -----------------------------------------------------------------------------
package store_rmw_unit_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_WORD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10
  } state_e;

  // A halfword must sit on an even byte, a word on a multiple of four.
  // Bytes can never be misaligned.
  function automatic logic is_misaligned(input mem_size_e size,
                                         input logic [1:0] byte_off);
    logic mis;
    case (size)
      MEM_HALF: mis = byte_off[0];
      MEM_WORD: mis = (byte_off != 2'b00);
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_rmw_unit_merge.sv
// -----------------------------------------------------------------------------
// store_rmw_unit_merge
// Combinational lane merge: replaces the addressed byte or halfword of an
// existing RAM word with the right-justified store data (little-endian).
// Ports:
//   old_word_i   in  32  word currently held in the RAM
//   store_data_i in  32  store data, right-justified
//   size_i       in  2   store size (mem_size_e)
//   byte_off_i   in  2   byte offset of the store inside the word
//   merged_o     out 32  word to write back
// -----------------------------------------------------------------------------
module store_rmw_unit_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] store_data_i,
  input  mem_size_e   size_i,
  input  logic [1:0]  byte_off_i,
  output logic [31:0] merged_o
);

  // Lane replacement; lanes not written keep their old contents.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      MEM_BYTE: begin
        case (byte_off_i)
          2'd0:    merged_o[7:0]   = store_data_i[7:0];
          2'd1:    merged_o[15:8]  = store_data_i[7:0];
          2'd2:    merged_o[23:16] = store_data_i[7:0];
          2'd3:    merged_o[31:24] = store_data_i[7:0];
          default: merged_o        = old_word_i;
        endcase
      end
      MEM_HALF: begin
        if (byte_off_i[1]) begin
          merged_o[31:16] = store_data_i[15:0];
        end else begin
          merged_o[15:0]  = store_data_i[15:0];
        end
      end
      MEM_WORD: merged_o = store_data_i;
      default:  merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
// MEM-stage store formatter for a word-wide data RAM without byte enables
// (1-cycle read latency). Aligned word stores write straight through in one
// cycle; byte and halfword stores run a READ -> WRITE read-modify-write
// sequence with the pipeline stalled. Misaligned stores are dropped and
// flagged.
// Ports:
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   MemWriteM   in   2       store size: 00 none, 01 byte, 10 half, 11 word
//   AluOutM     in   32      byte address of the store
//   WriteDataM  in   32      store data, right-justified
//   MemRdData   in   DATA_W  RAM read data (valid cycle after a read)
//   MemEn       out  1       RAM enable
//   MemWe       out  1       RAM write enable
//   MemAddr     out  ADDR_W  RAM word address
//   MemWrData   out  DATA_W  RAM write data
//   StallM      out  1       holds IF..MEM pipeline registers
//   AlignErrM   out  1       misaligned store was dropped (this cycle)
//   DoneM       out  1       pulse the cycle after a RAM write was issued
// -----------------------------------------------------------------------------
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32  // fixed at 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        MemWriteM,
  input  logic [31:0]       AluOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              StallM,
  output logic              AlignErrM,
  output logic              DoneM
);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;   // latched byte address (word + lane)
  logic [DATA_W-1:0] data_q, data_d;
  mem_size_e         size_q, size_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic              done_q, done_d;

  mem_size_e         req_size_s;
  logic              req_misaligned_s;
  logic [DATA_W-1:0] merged_s;

  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wr_data_s;
  logic              stall_s;
  logic              align_err_s;

  // Address bits above the RAM range are deliberately ignored.
  logic              unused_addr_s;
  assign unused_addr_s = ^AluOutM[31:ADDR_W+2];

  assign req_size_s       = mem_size_e'(MemWriteM);
  assign req_misaligned_s = is_misaligned(req_size_s, AluOutM[1:0]);

  // The merge works on the latched request: the stalled instruction keeps
  // presenting the same data, but the latch makes the sequence independent
  // of what the pipeline drives during READ/WRITE.
  store_rmw_unit_merge u_merge (
    .old_word_i   (MemRdData),
    .store_data_i (data_q),
    .size_i       (size_q),
    .byte_off_i   (addr_q[1:0]),
    .merged_o     (merged_s)
  );

  // Next-state and RAM/pipeline control for the store sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    size_d        = size_q;
    merge_d       = merge_q;
    mem_en_s      = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = {ADDR_W{1'b0}};
    mem_wr_data_s = {DATA_W{1'b0}};
    stall_s       = 1'b0;
    align_err_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_misaligned_s) begin
          align_err_s = 1'b1;
        end else if (req_size_s == MEM_WORD) begin
          mem_en_s      = 1'b1;
          mem_we_s      = 1'b1;
          mem_addr_s    = AluOutM[ADDR_W+1:2];
          mem_wr_data_s = WriteDataM;
        end else if ((req_size_s == MEM_BYTE) || (req_size_s == MEM_HALF)) begin
          // Issue the RAM read now; data returns while in READ.
          addr_d     = AluOutM[ADDR_W+1:0];
          data_d     = WriteDataM;
          size_d     = req_size_s;
          mem_en_s   = 1'b1;
          mem_addr_s = AluOutM[ADDR_W+1:2];
          stall_s    = 1'b1;
          state_d    = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_READ: begin
        merge_d = merged_s;
        stall_s = 1'b1;
        state_d = S_WRITE;
      end

      // Stall released here so the pipeline advances on this same edge.
      S_WRITE: begin
        mem_en_s      = 1'b1;
        mem_we_s      = 1'b1;
        mem_addr_s    = addr_q[ADDR_W+1:2];
        mem_wr_data_s = merge_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = mem_en_s & mem_we_s;
  end

  // Sequencer state, request latches, merge register and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= {(ADDR_W+2){1'b0}};
      data_q  <= {DATA_W{1'b0}};
      size_q  <= MEM_NONE;
      merge_q <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      merge_q <= merge_d;
      done_q  <= done_d;
    end
  end

  // Control strobes are masked by reset directly: in IDLE they follow the
  // live request, which could otherwise reach the RAM while reset is held.
  assign MemEn     = mem_en_s    & ~reset;
  assign MemWe     = mem_we_s    & ~reset;
  assign StallM    = stall_s     & ~reset;
  assign AlignErrM = align_err_s & ~reset;
  assign MemAddr   = mem_addr_s;
  assign MemWrData = mem_wr_data_s;
  assign DoneM     = done_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// -----------------------------------------------------------------------------
// tb_store_rmw_unit
// Directed bench for store_rmw_unit with a word-wide, 1-cycle-latency RAM
// model. Inputs change 1 time unit after the rising edge; outputs are
// checked 3 time units after the edge.
// -----------------------------------------------------------------------------
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  MemWriteM;
  logic [31:0] AluOutM;
  logic [31:0] WriteDataM;
  logic [31:0] MemRdData;
  logic        MemEn;
  logic        MemWe;
  logic [9:0]  MemAddr;
  logic [31:0] MemWrData;
  logic        StallM;
  logic        AlignErrM;
  logic        DoneM;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  // RAM model plus a bench-side preload port.
  logic [31:0] ram [0:1023];
  logic [31:0] rd_q;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'd0;
  logic [31:0] pre_data = 32'd0;

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .AluOutM    (AluOutM),
    .WriteDataM (WriteDataM),
    .MemRdData  (MemRdData),
    .MemEn      (MemEn),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWrData  (MemWrData),
    .StallM     (StallM),
    .AlignErrM  (AlignErrM),
    .DoneM      (DoneM)
  );

  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (MemEn && MemWe) begin
      ram[MemAddr] <= MemWrData;
    end else if (MemEn) begin
      rd_q <= ram[MemAddr];
    end
  end
  assign MemRdData = rd_q;

  always @(negedge clk) begin
    if (MemEn && MemWe) we_cnt <= we_cnt + 1;
    if (DoneM) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pre(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic idle(input string tag, input logic exp_done);
    MemWriteM = 2'b00; AluOutM = 32'd0; WriteDataM = 32'd0;
    #2;
    chk({tag, "/done"}, DoneM, exp_done);
    chk({tag, "/idle_en"}, MemEn, 1'b0);
    tick();
  endtask

  // Full 3-cycle read-modify-write with per-cycle checks; returns one unit
  // after the edge on which the merged word is written.
  task automatic subword(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [9:0] exp_addr,
                         input logic [31:0] exp_word, input logic exp_done0);
    MemWriteM = sz; AluOutM = a; WriteDataM = d;
    #2;
    chk({tag, "/c1_en"}, MemEn, 1'b1);
    chk({tag, "/c1_we"}, MemWe, 1'b0);
    chk({tag, "/c1_stall"}, StallM, 1'b1);
    chk({tag, "/c1_addr"}, MemAddr, exp_addr);
    chk({tag, "/c1_done"}, DoneM, exp_done0);
    tick(); #2;
    chk({tag, "/c2_stall"}, StallM, 1'b1);
    chk({tag, "/c2_en"}, MemEn, 1'b0);
    chk({tag, "/c2_done"}, DoneM, 1'b0);
    tick(); #2;
    chk({tag, "/c3_en"}, MemEn, 1'b1);
    chk({tag, "/c3_we"}, MemWe, 1'b1);
    chk({tag, "/c3_stall"}, StallM, 1'b0);
    chk({tag, "/c3_addr"}, MemAddr, exp_addr);
    chk({tag, "/c3_data"}, MemWrData, exp_word);
    tick();
  endtask

  initial begin
    int we0;
    int done0;
    reset = 1'b1; MemWriteM = 2'b00; AluOutM = 32'd0; WriteDataM = 32'd0;

    // Reset: strobes held low even with a live word-store request.
    #2;
    chk("rst/done", DoneM, 1'b0);
    chk("rst/stall", StallM, 1'b0);
    MemWriteM = 2'b11; AluOutM = 32'h10; WriteDataM = 32'h1;
    #1;
    chk("rst/en_forced", MemEn, 1'b0);
    chk("rst/we_forced", MemWe, 1'b0);
    MemWriteM = 2'b00;
    tick(); tick();
    reset = 1'b0;

    // 1. Word store.
    MemWriteM = 2'b11; AluOutM = 32'h10; WriteDataM = 32'hDEADBEEF;
    #2;
    chk("word/en", MemEn, 1'b1);
    chk("word/we", MemWe, 1'b1);
    chk("word/addr", MemAddr, 10'd4);
    chk("word/data", MemWrData, 32'hDEADBEEF);
    chk("word/stall", StallM, 1'b0);
    chk("word/aerr", AlignErrM, 1'b0);
    tick();
    idle("word_n1", 1'b1);
    idle("word_n2", 1'b0);
    chk("word/ram", ram[4], 32'hDEADBEEF);

    // Word store at top of RAM; high address bits beyond the RAM ignored.
    MemWriteM = 2'b11; AluOutM = 32'hABCD_0FFC; WriteDataM = 32'h0BADF00D;
    #2;
    chk("wtop/addr", MemAddr, 10'h3FF);
    tick();
    idle("wtop_n1", 1'b1);
    chk("wtop/ram", ram[1023], 32'h0BADF00D);

    // 2. Byte store, lane 2.
    pre(10'd4, 32'h11223344);
    subword("byte2", 2'b01, 32'h12, 32'h000000AB, 10'd4, 32'h11AB3344, 1'b0);
    idle("byte2_n", 1'b1);
    chk("byte2/ram", ram[4], 32'h11AB3344);

    // 3. Remaining byte lanes (upper data bits must be discarded) and halves.
    pre(10'd4, 32'h11223344);
    subword("byte0", 2'b01, 32'h10, 32'h5A5A5AAB, 10'd4, 32'h112233AB, 1'b0);
    idle("byte0_n", 1'b1);
    pre(10'd4, 32'h11223344);
    subword("byte1", 2'b01, 32'h11, 32'h000000AB, 10'd4, 32'h1122AB44, 1'b0);
    idle("byte1_n", 1'b1);
    pre(10'd4, 32'h11223344);
    subword("byte3", 2'b01, 32'h13, 32'h000000AB, 10'd4, 32'hAB223344, 1'b0);
    idle("byte3_n", 1'b1);
    pre(10'd4, 32'h11223344);
    subword("half0", 2'b10, 32'h10, 32'hFFFFCAFE, 10'd4, 32'h1122CAFE, 1'b0);
    idle("half0_n", 1'b1);
    pre(10'd4, 32'h11223344);
    subword("half1", 2'b10, 32'h12, 32'hFFFFCAFE, 10'd4, 32'hCAFE3344, 1'b0);
    idle("half1_n", 1'b1);
    chk("half1/ram", ram[4], 32'hCAFE3344);
    pre(10'd4, 32'h11223344);
    subword("byte_hiaddr", 2'b01, 32'hFFFFF011, 32'h000000AB, 10'd4, 32'h1122AB44, 1'b0);
    idle("byte_hiaddr_n", 1'b1);

    // 4. Misaligned half and word stores.
    pre(10'd4, 32'h11223344);
    MemWriteM = 2'b10; AluOutM = 32'h13; WriteDataM = 32'h00001234;
    #2;
    chk("mis_h/aerr", AlignErrM, 1'b1);
    chk("mis_h/en", MemEn, 1'b0);
    chk("mis_h/stall", StallM, 1'b0);
    tick();
    MemWriteM = 2'b11; AluOutM = 32'h12; WriteDataM = 32'h55667788;
    #2;
    chk("mis_w/aerr", AlignErrM, 1'b1);
    chk("mis_w/en", MemEn, 1'b0);
    chk("mis_w/stall", StallM, 1'b0);
    tick();
    idle("mis_n", 1'b0);
    chk("mis/aerr_clear", AlignErrM, 1'b0);
    chk("mis/ram", ram[4], 32'h11223344);

    // 5. Back-to-back byte stores, no gap cycle.
    pre(10'd4, 32'h00000000);
    done0 = done_cnt;
    subword("b2b_a", 2'b01, 32'h10, 32'h000000AA, 10'd4, 32'h000000AA, 1'b0);
    subword("b2b_b", 2'b01, 32'h11, 32'h000000BB, 10'd4, 32'h0000BBAA, 1'b1);
    idle("b2b_n", 1'b1);
    chk("b2b/ram", ram[4], 32'h0000BBAA);
    chk("b2b/dones", done_cnt - done0, 32'd2);

    // 6. Reset asserted asynchronously while in READ.
    pre(10'd4, 32'h11223344);
    MemWriteM = 2'b01; AluOutM = 32'h10; WriteDataM = 32'h00000077;
    #2;
    tick(); #2;
    chk("rstrd/stall_pre", StallM, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstrd/stall", StallM, 1'b0);
    chk("rstrd/en", MemEn, 1'b0);
    MemWriteM = 2'b00;
    tick();
    reset = 1'b0;
    we0 = we_cnt;
    idle("rstrd_n1", 1'b0);
    idle("rstrd_n2", 1'b0);
    idle("rstrd_n3", 1'b0);
    chk("rstrd/no_we", we_cnt - we0, 32'd0);
    chk("rstrd/ram", ram[4], 32'h11223344);
    subword("rstrd_next", 2'b01, 32'h10, 32'h00000077, 10'd4, 32'h11223377, 1'b0);
    idle("rstrd_next_n", 1'b1);
    chk("rstrd_next/ram", ram[4], 32'h11223377);

    // Reset asserted while in WRITE: the write strobe is withdrawn at once.
    pre(10'd4, 32'h11223344);
    MemWriteM = 2'b01; AluOutM = 32'h11; WriteDataM = 32'h00000099;
    #2;
    tick(); #2;
    tick(); #2;
    chk("rstwr/we_pre", MemWe, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstwr/we", MemWe, 1'b0);
    MemWriteM = 2'b00;
    tick();
    reset = 1'b0;
    idle("rstwr_n", 1'b0);
    chk("rstwr/ram", ram[4], 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
